// File: rtl/ace_instbuf.sv
// Instruction buffer between fetch and decode: compacts a masked fetch group into a
// circular queue and presents up to DEC_W oldest entries combinationally.
module ace_instbuf #(
  parameter int unsigned FETCH_W = 8,
  parameter int unsigned DEC_W   = 4,
  parameter int unsigned INST_W  = 32,
  parameter int unsigned DEPTH   = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         retire_flush_i,
  input  logic [FETCH_W*INST_W-1:0]    fetch_inst_i,
  input  logic [FETCH_W-1:0]           fetch_vld_i,
  input  logic                         dec_rdy_i,
  output logic [DEC_W*INST_W-1:0]      inst_o,
  output logic [DEC_W-1:0]             vld_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_TH_C = CW'(DEPTH - FETCH_W);
  localparam logic [CW-1:0] DEC_W_C   = CW'(DEC_W);

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic [PW-1:0]     w_off [FETCH_W];
  logic [CW-1:0]     w_npush;
  logic [CW-1:0]     w_npop;
  logic [CW-1:0]     w_count_nxt;
  logic              w_push;
  logic              w_pop;

  // Prefix popcount: each set slot lands at tail + number of set slots below it.
  always_comb begin
    w_npush = '0;
    for (int unsigned k = 0; k < FETCH_W; k++) begin
      w_off[k] = w_npush[PW-1:0];
      w_npush  = w_npush + CW'(fetch_vld_i[k]);
    end
  end

  always_comb begin
    w_push      = (|fetch_vld_i) && !full_o && !retire_flush_i;
    w_pop       = dec_rdy_i && !retire_flush_i;
    w_npop      = '0;
    if (w_pop) begin
      w_npop = (r_count < DEC_W_C) ? r_count : DEC_W_C;
    end
    w_count_nxt = r_count + (w_push ? w_npush : '0) - w_npop;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (retire_flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + w_npush[PW-1:0];
      end
      r_head  <= r_head + w_npop[PW-1:0];
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      for (int unsigned k = 0; k < FETCH_W; k++) begin
        if (fetch_vld_i[k]) begin
          r_mem[r_tail + w_off[k]] <= fetch_inst_i[k*INST_W +: INST_W];
        end
      end
    end
  end

  always_comb begin
    vld_o  = '0;
    inst_o = '0;
    for (int unsigned k = 0; k < DEC_W; k++) begin
      vld_o[k] = (r_count > CW'(k));
      if (vld_o[k]) begin
        inst_o[k*INST_W +: INST_W] = r_mem[r_head + PW'(k)];
      end
    end
  end

  assign full_o  = (r_count > FULL_TH_C);
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

  a_no_overflow : assert property (@(posedge clock) disable iff (!reset_n)
    (retire_flush_i || (w_count_nxt <= DEPTH_C)));

endmodule

// File: tb/tb_ace_instbuf.sv
// Bench for ace_instbuf: directed scenarios plus randomized traffic against a queue model.
module tb_ace_instbuf;

  logic          clock;
  logic          reset_n;
  logic          retire_flush_i;
  logic [255:0]  fetch_inst_i;
  logic [7:0]    fetch_vld_i;
  logic          dec_rdy_i;
  logic [127:0]  inst_o;
  logic [3:0]    vld_o;
  logic          full_o;
  logic          empty_o;
  logic [4:0]    count_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] mq[$];

  ace_instbuf #(.FETCH_W(8), .DEC_W(4), .INST_W(32), .DEPTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .retire_flush_i(retire_flush_i),
    .fetch_inst_i(fetch_inst_i), .fetch_vld_i(fetch_vld_i), .dec_rdy_i(dec_rdy_i),
    .inst_o(inst_o), .vld_o(vld_o), .full_o(full_o), .empty_o(empty_o), .count_o(count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [255:0] mk(input logic [31:0] base);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = base + 32'(k);
    return d;
  endfunction

  // One clock: drive after negedge, update the queue model at posedge, return at negedge.
  task automatic cyc(input logic [7:0] v, input logic [255:0] data, input logic rdy,
                     input logic fl);
    int n;
    bit pushok;
    fetch_vld_i    = v;
    fetch_inst_i   = data;
    dec_rdy_i      = rdy;
    retire_flush_i = fl;
    pushok = (v != 8'h00) && ((16 - mq.size()) >= 8);
    @(posedge clock);
    if (fl) begin
      mq.delete();
    end else begin
      if (rdy) begin
        n = (mq.size() < 4) ? mq.size() : 4;
        repeat (n) void'(mq.pop_front());
      end
      if (pushok) begin
        for (int k = 0; k < 8; k++) if (v[k]) mq.push_back(data[k*32 +: 32]);
      end
    end
    @(negedge clock);
    fetch_vld_i    = '0;
    dec_rdy_i      = 1'b0;
    retire_flush_i = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count_o); end
    checks++; if (vld_o !== 4'b0000) begin errors++; $display("FAIL rst_vld got %b exp 0000", vld_o); end
    checks++; if (inst_o !== '0) begin errors++; $display("FAIL rst_inst got %h exp 0", inst_o); end
    checks++; if (full_o !== 1'b0 || empty_o !== 1'b1) begin errors++; $display("FAIL rst_flags full %b empty %b exp 0 1", full_o, empty_o); end
    reset_n = 1'b1;
    cyc(8'hFF, mk(32'h10), 1'b0, 1'b0);
    cyc(8'h01, mk(32'h18), 1'b0, 1'b0);
    checks++; if (count_o !== 5'd9) begin errors++; $display("FAIL pre_rst_count got %0d exp 9", count_o); end
    #2 reset_n = 1'b0;
    #1;
    mq.delete();
    checks++; if (count_o !== 5'd0 || vld_o !== 4'b0000 || empty_o !== 1'b1) begin
      errors++; $display("FAIL async_rst count %0d vld %b empty %b exp 0 0000 1", count_o, vld_o, empty_o);
    end
    @(negedge clock);
    reset_n = 1'b1;
    cyc(8'h03, mk(32'h200), 1'b0, 1'b0);
    checks++; if (inst_o[31:0] !== 32'h200 || inst_o[63:32] !== 32'h201 || vld_o !== 4'b0011) begin
      errors++; $display("FAIL post_rst_push inst %h %h vld %b exp 200 201 0011", inst_o[31:0], inst_o[63:32], vld_o);
    end
    cyc(8'h00, '0, 1'b1, 1'b0);
  endtask

  task automatic test_full_group;
    cyc(8'hFF, mk(32'h100), 1'b1, 1'b0);
    checks++; if (inst_o !== {32'h103, 32'h102, 32'h101, 32'h100} || vld_o !== 4'hF) begin
      errors++; $display("FAIL grp_c1 got %h vld %b exp 103..100 1111", inst_o, vld_o);
    end
    cyc(8'h00, '0, 1'b1, 1'b0);
    checks++; if (inst_o !== {32'h107, 32'h106, 32'h105, 32'h104} || count_o !== 5'd4) begin
      errors++; $display("FAIL grp_c2 got %h count %0d exp 107..104 4", inst_o, count_o);
    end
    cyc(8'h00, '0, 1'b1, 1'b0);
    checks++; if (empty_o !== 1'b1 || inst_o !== '0) begin
      errors++; $display("FAIL grp_c3 empty %b inst %h exp 1 0", empty_o, inst_o);
    end
  endtask

  task automatic test_sparse;
    cyc(8'b1010_0101, mk(32'hA0), 1'b0, 1'b0);
    checks++; if (count_o !== 5'd4) begin errors++; $display("FAIL sparse_count got %0d exp 4", count_o); end
    checks++; if (inst_o !== {32'hA7, 32'hA5, 32'hA2, 32'hA0} || vld_o !== 4'b1111) begin
      errors++; $display("FAIL sparse_inst got %h vld %b exp A7 A5 A2 A0 1111", inst_o, vld_o);
    end
    cyc(8'h00, '0, 1'b1, 1'b0);
  endtask

  task automatic test_full_wrap;
    cyc(8'hFF, mk(32'h300), 1'b0, 1'b0);
    checks++; if (count_o !== 5'd8 || full_o !== 1'b0) begin
      errors++; $display("FAIL wrap_8 count %0d full %b exp 8 0", count_o, full_o);
    end
    cyc(8'h01, mk(32'h310), 1'b0, 1'b0);
    checks++; if (count_o !== 5'd9 || full_o !== 1'b1) begin
      errors++; $display("FAIL wrap_9 count %0d full %b exp 9 1", count_o, full_o);
    end
    cyc(8'hFF, mk(32'h320), 1'b0, 1'b0);
    checks++; if (count_o !== 5'd9 || inst_o !== {32'h303, 32'h302, 32'h301, 32'h300}) begin
      errors++; $display("FAIL wrap_drop count %0d inst %h exp 9 303..300", count_o, inst_o);
    end
    for (int r = 0; r < 12; r++) begin
      if (r < 5) cyc(8'hFF, mk(32'h400 + 32'(r) * 32'h10), 1'b1, 1'b0);
      else       cyc(8'h00, '0, 1'b1, 1'b0);
      checks++; if (count_o !== 5'(mq.size())) begin
        errors++; $display("FAIL wrap_count r%0d got %0d exp %0d", r, count_o, mq.size());
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (inst_o[k*32 +: 32] !== ((k < mq.size()) ? mq[k] : 32'h0)) begin
          errors++; $display("FAIL wrap_order r%0d slot %0d got %h exp %h", r, k,
                             inst_o[k*32 +: 32], (k < mq.size()) ? mq[k] : 32'h0);
        end
      end
    end
  endtask

  task automatic test_flush;
    cyc(8'hFF, mk(32'h500), 1'b0, 1'b0);
    cyc(8'h0F, mk(32'h508), 1'b0, 1'b0);
    checks++; if (count_o !== 5'd12) begin errors++; $display("FAIL flush_pre count %0d exp 12", count_o); end
    cyc(8'hFF, mk(32'h5F0), 1'b1, 1'b1);
    checks++; if (count_o !== 5'd0 || vld_o !== 4'b0000 || empty_o !== 1'b1) begin
      errors++; $display("FAIL flush count %0d vld %b empty %b exp 0 0000 1", count_o, vld_o, empty_o);
    end
    cyc(8'h03, mk(32'h600), 1'b0, 1'b0);
    checks++; if (inst_o !== {64'h0, 32'h601, 32'h600} || count_o !== 5'd2) begin
      errors++; $display("FAIL flush_after inst %h count %0d exp 0 0 601 600 2", inst_o, count_o);
    end
    cyc(8'h00, '0, 1'b1, 1'b0);
  endtask

  task automatic test_partial_pop;
    cyc(8'h07, mk(32'h700), 1'b0, 1'b0);
    checks++; if (vld_o !== 4'b0111) begin errors++; $display("FAIL ppop_vld got %b exp 0111", vld_o); end
    cyc(8'h00, '0, 1'b1, 1'b0);
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL ppop_count got %0d exp 0", count_o); end
    cyc(8'h07, mk(32'h710), 1'b0, 1'b0);
    cyc(8'h03, mk(32'h720), 1'b1, 1'b0);
    checks++; if (count_o !== 5'd2 || inst_o !== {64'h0, 32'h721, 32'h720} || vld_o !== 4'b0011) begin
      errors++; $display("FAIL ppop_push count %0d inst %h vld %b exp 2 0 0 721 720 0011", count_o, inst_o, vld_o);
    end
    cyc(8'h00, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    logic [255:0] d;
    logic [7:0]   v;
    logic         rdy;
    logic         fl;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      v   = 8'($urandom);
      rdy = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 29) == 0);
      cyc(v, d, rdy, fl);
      checks++; if (count_o !== 5'(mq.size())) begin
        errors++; $display("FAIL rnd_count i%0d got %0d exp %0d", i, count_o, mq.size());
      end
      checks++; if (full_o !== (mq.size() > 8) || empty_o !== (mq.size() == 0)) begin
        errors++; $display("FAIL rnd_flags i%0d full %b empty %b size %0d", i, full_o, empty_o, mq.size());
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (vld_o[k] !== (k < mq.size()) || inst_o[k*32 +: 32] !== ((k < mq.size()) ? mq[k] : 32'h0)) begin
          errors++; $display("FAIL rnd_slot i%0d slot %0d vld %b inst %h exp %h", i, k, vld_o[k],
                             inst_o[k*32 +: 32], (k < mq.size()) ? mq[k] : 32'h0);
        end
      end
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    retire_flush_i = 1'b0;
    fetch_inst_i   = '0;
    fetch_vld_i    = '0;
    dec_rdy_i      = 1'b0;
    repeat (2) @(negedge clock);
    test_reset;
    test_full_group;
    test_sparse;
    test_full_wrap;
    test_flush;
    test_partial_pop;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
